// File: rtl/flasher_pkg.sv
// Shared types and helpers for the bound-flasher family.
package flasher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_e;

    // Width of one packed bound field in the phase tables.
    localparam int unsigned BOUND_W   = 8;
    // Upper limits that size the helper-function arguments.
    localparam int unsigned MAX_PHASE = 256;
    localparam int unsigned MAX_LEDS  = 256;
    localparam int unsigned BVEC_W    = BOUND_W * MAX_PHASE;

    // Thermometer code: the lowest `lvl` bits set, clipped to `width` lamps.
    function automatic logic [MAX_LEDS-1:0] therm(input int unsigned lvl, input int unsigned width);
        return ~({MAX_LEDS{1'b1}} << lvl) & ~({MAX_LEDS{1'b1}} << width);
    endfunction

    // Extract bound field `idx` from a packed table, field 0 in the LSBs.
    function automatic logic [BOUND_W-1:0] bound_at(input logic [BVEC_W-1:0] vec, input int unsigned idx);
        return BOUND_W'(vec >> (idx * BOUND_W));
    endfunction

endpackage

// File: rtl/flash_tick_gen.sv
// Step prescaler: asserts tick_o once every STEP_DIV enabled cycles.
module flash_tick_gen #(
    parameter int unsigned STEP_DIV = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned    CW   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(STEP_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = en_i && (cnt_q == LAST);

    // Wrap at LAST; restart from zero on clear or while disabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !en_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sweep_flasher.sv
// Thermometer-bar sweeper: bounces a lit bar between per-phase high/low
// bounds after a FLICK rising edge, with kickback and loop options.
module sweep_flasher
    import flasher_pkg::*;
#(
    parameter int unsigned                 WIDTH    = 16,
    parameter int unsigned                 NPHASE   = 3,
    parameter logic [BOUND_W*NPHASE-1:0]   PHASE_HI = {8'd6, 8'd11, 8'd16},
    parameter logic [BOUND_W*NPHASE-1:0]   PHASE_LO = {8'd1, 8'd1, 8'd6},
    parameter logic [WIDTH:0]              KB_MASK  = (WIDTH + 1)'(7'b1000010),
    parameter int unsigned                 STEP_DIV = 1,
    localparam int unsigned                PW       = (NPHASE > 1) ? $clog2(NPHASE) : 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             FLICK,
    input  logic             LOOP,
    output logic [WIDTH-1:0] LED,
    output logic             BUSY,
    output logic [PW-1:0]    PHASE
);

    localparam logic [BVEC_W-1:0] HI_VEC     = BVEC_W'(PHASE_HI);
    localparam logic [BVEC_W-1:0] LO_VEC     = BVEC_W'(PHASE_LO);
    localparam logic [PW-1:0]     LAST_PHASE = PW'(NPHASE - 1);

    // Parameter sanity, rejected at elaboration.
    if (WIDTH < 1 || WIDTH > 255) begin : g_bad_width
        $fatal(1, "sweep_flasher: WIDTH must be 1..255");
    end
    if (STEP_DIV < 1) begin : g_bad_div
        $fatal(1, "sweep_flasher: STEP_DIV must be >= 1");
    end
    if (NPHASE < 1 || NPHASE > MAX_PHASE) begin : g_bad_nphase
        $fatal(1, "sweep_flasher: NPHASE out of range");
    end
    for (genvar p = 0; p < NPHASE; p++) begin : g_chk
        localparam int unsigned HI_P = 32'(PHASE_HI[p*BOUND_W +: BOUND_W]);
        localparam int unsigned LO_P = 32'(PHASE_LO[p*BOUND_W +: BOUND_W]);
        if (LO_P < 1 || LO_P >= HI_P || HI_P > WIDTH) begin : g_bad_bound
            $fatal(1, "sweep_flasher: need 1 <= LO < HI <= WIDTH for every phase");
        end
    end

    state_e           state_q, state_d;
    logic [7:0]       lvl_q, lvl_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic             flick_q;
    logic [WIDTH-1:0] led_q, led_d;
    logic             busy_q;

    logic             rise;
    logic             tick;
    logic             kb_hit;
    logic             clr;
    logic [7:0]       hi_cur;
    logic [7:0]       lo_cur;

    assign rise   = FLICK & ~flick_q;
    assign hi_cur = bound_at(HI_VEC, 32'(phase_q));
    assign lo_cur = bound_at(LO_VEC, 32'(phase_q));
    assign kb_hit = |(KB_MASK & ((WIDTH + 1)'(1) << lvl_q));

    flash_tick_gen #(
        .STEP_DIV (STEP_DIV)
    ) u_tick (
        .clk_i  (CLK),
        .rst_i  (RST),
        .clr_i  (clr),
        .en_i   (state_q != ST_IDLE),
        .tick_o (tick)
    );

    // Next-state decode; a kickback pre-empts a same-cycle step in DOWN.
    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        phase_d = phase_q;
        clr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                lvl_d   = '0;
                phase_d = '0;
                if (rise) begin
                    state_d = ST_UP;
                    clr     = 1'b1;
                end
            end
            ST_UP: begin
                if (tick) begin
                    if (lvl_q >= hi_cur) begin
                        state_d = ST_DOWN;
                        lvl_d   = lvl_q - 8'd1;
                    end else begin
                        lvl_d   = lvl_q + 8'd1;
                    end
                end
            end
            ST_DOWN: begin
                if (rise && kb_hit) begin
                    state_d = ST_UP;
                    phase_d = (phase_q == '0) ? '0 : phase_q - 1'b1;
                    lvl_d   = lvl_q + 8'd1;
                    clr     = 1'b1;
                end else if (tick) begin
                    if (lvl_q != lo_cur) begin
                        lvl_d   = lvl_q - 8'd1;
                    end else if (phase_q != LAST_PHASE) begin
                        state_d = ST_UP;
                        phase_d = phase_q + 1'b1;
                        lvl_d   = lvl_q + 8'd1;
                    end else if (LOOP) begin
                        state_d = ST_UP;
                        phase_d = '0;
                        lvl_d   = lvl_q + 8'd1;
                    end else begin
                        state_d = ST_IDLE;
                        phase_d = '0;
                        lvl_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                lvl_d   = '0;
                phase_d = '0;
            end
        endcase
    end

    assign led_d = WIDTH'(therm(32'(lvl_d), WIDTH));

    // State, bar level and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            lvl_q   <= '0;
            phase_q <= '0;
            flick_q <= 1'b0;
            led_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lvl_q   <= lvl_d;
            phase_q <= phase_d;
            flick_q <= FLICK;
            led_q   <= led_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign LED   = led_q;
    assign BUSY  = busy_q;
    assign PHASE = phase_q;

endmodule

// File: tb/tb_sweep_flasher.sv
// Scoreboard bench for sweep_flasher: a default instance (A) and a
// slow single-phase instance (B).
module tb_sweep_flasher;

    logic        CLK = 1'b0;
    logic        RST;
    logic        flick_a, loop_a, flick_b, loop_b;
    logic [15:0] led_a;
    logic        busy_a;
    logic [1:0]  phase_a;
    logic [7:0]  led_b;
    logic        busy_b;
    logic [0:0]  phase_b;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        bit          sel;
        logic [15:0] led;
        logic        busy;
        logic [1:0]  phase;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    sweep_flasher u_a (
        .CLK   (CLK),
        .RST   (RST),
        .FLICK (flick_a),
        .LOOP  (loop_a),
        .LED   (led_a),
        .BUSY  (busy_a),
        .PHASE (phase_a)
    );

    sweep_flasher #(
        .WIDTH    (8),
        .NPHASE   (1),
        .PHASE_HI (8'd8),
        .PHASE_LO (8'd2),
        .KB_MASK  (9'd0),
        .STEP_DIV (4)
    ) u_b (
        .CLK   (CLK),
        .RST   (RST),
        .FLICK (flick_b),
        .LOOP  (loop_b),
        .LED   (led_b),
        .BUSY  (busy_b),
        .PHASE (phase_b)
    );

    // Monitor: compare every expectation due after the current edge.
    always @(negedge CLK) begin
        logic [15:0] al;
        logic        ab;
        logic [1:0]  ap;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.sel) begin
                al = {8'h00, led_b};
                ab = busy_b;
                ap = {1'b0, phase_b};
            end else begin
                al = led_a;
                ab = busy_a;
                ap = phase_a;
            end
            checks++;
            if (e.cyc != cyc || al !== e.led || ab !== e.busy || ap !== e.phase) begin
                errors++;
                $display("FAIL %s edge %0d (due %0d): got led=%h busy=%b phase=%0d, want led=%h busy=%b phase=%0d",
                         e.name, cyc, e.cyc, al, ab, ap, e.led, e.busy, e.phase);
            end
        end
    end

    task automatic exp_at(input int c, input bit sel, input logic [15:0] led,
                          input logic busy, input logic [1:0] ph, input string nm);
        exp_t x;
        x.cyc = c; x.sel = sel; x.led = led; x.busy = busy; x.phase = ph; x.name = nm;
        sb.push_back(x);
    endtask

    task automatic tick1();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        exp_at(cyc + 2, 1'b0, 16'h0000, 1'b0, 2'd0, "reset_a");
        exp_at(cyc + 2, 1'b1, 16'h0000, 1'b0, 2'd0, "reset_b");
        RST = 1'b1;
        tick1();
        tick1();
        RST = 1'b0;
    endtask

    initial begin
        int base;
        RST = 1'b1; flick_a = 1'b1; loop_a = 1'b0; flick_b = 1'b0; loop_b = 1'b0;

        // Reset state, then FLICK already high as reset releases.
        exp_at(1, 1'b0, 16'h0000, 1'b0, 2'd0, "rst_a");
        exp_at(1, 1'b1, 16'h0000, 1'b0, 2'd0, "rst_b");
        exp_at(3, 1'b0, 16'h0000, 1'b0, 2'd0, "rst_hold_a");
        exp_at(4, 1'b0, 16'h0000, 1'b1, 2'd0, "rise_after_rst");
        repeat (3) tick1();
        RST = 1'b0;
        tick1();
        flick_a = 1'b0;
        do_reset();

        // Full default sweep; extra FLICK rise in UP is ignored.
        base = cyc + 1;
        exp_at(base + 0,  1'b0, 16'h0000, 1'b1, 2'd0, "sw_start");
        exp_at(base + 1,  1'b0, 16'h0001, 1'b1, 2'd0, "sw_step1");
        exp_at(base + 16, 1'b0, 16'hFFFF, 1'b1, 2'd0, "sw_top");
        exp_at(base + 17, 1'b0, 16'h7FFF, 1'b1, 2'd0, "sw_turn");
        exp_at(base + 26, 1'b0, 16'h003F, 1'b1, 2'd0, "sw_lo0");
        exp_at(base + 27, 1'b0, 16'h007F, 1'b1, 2'd1, "sw_ph1");
        exp_at(base + 31, 1'b0, 16'h07FF, 1'b1, 2'd1, "sw_hi1");
        exp_at(base + 41, 1'b0, 16'h0001, 1'b1, 2'd1, "sw_lo1");
        exp_at(base + 42, 1'b0, 16'h0003, 1'b1, 2'd2, "sw_ph2");
        exp_at(base + 46, 1'b0, 16'h003F, 1'b1, 2'd2, "sw_hi2");
        exp_at(base + 51, 1'b0, 16'h0001, 1'b1, 2'd2, "sw_lo2");
        exp_at(base + 52, 1'b0, 16'h0000, 1'b0, 2'd0, "sw_idle");
        for (int n = 0; n <= 54; n++) begin
            flick_a = (n < 3 || n == 5);
            tick1();
        end
        flick_a = 1'b0;

        // Reset mid-sweep at lvl 9, phase 1 UP, then restart.
        base = cyc + 1;
        exp_at(base + 29, 1'b0, 16'h01FF, 1'b1, 2'd1, "mr_before");
        exp_at(base + 30, 1'b0, 16'h0000, 1'b0, 2'd0, "mr_reset");
        exp_at(base + 33, 1'b0, 16'h0000, 1'b1, 2'd0, "mr_restart");
        exp_at(base + 34, 1'b0, 16'h0001, 1'b1, 2'd0, "mr_step1");
        exp_at(base + 35, 1'b0, 16'h0003, 1'b1, 2'd0, "mr_step2");
        for (int n = 0; n <= 35; n++) begin
            RST     = (n == 30);
            flick_a = (n == 0 || n == 33);
            tick1();
        end
        flick_a = 1'b0;
        do_reset();

        // Kickbacks at counts 6 (phase 0) and 1 (phase 1); non-KB rise at 9.
        base = cyc + 1;
        exp_at(base + 26, 1'b0, 16'h003F, 1'b1, 2'd0, "kb_pre");
        exp_at(base + 27, 1'b0, 16'h007F, 1'b1, 2'd0, "kb6_sat");
        exp_at(base + 36, 1'b0, 16'hFFFF, 1'b1, 2'd0, "kb6_top");
        exp_at(base + 43, 1'b0, 16'h01FF, 1'b1, 2'd0, "nokb_pre");
        exp_at(base + 44, 1'b0, 16'h00FF, 1'b1, 2'd0, "nokb_ign");
        exp_at(base + 47, 1'b0, 16'h007F, 1'b1, 2'd1, "kb_ph1");
        exp_at(base + 61, 1'b0, 16'h0001, 1'b1, 2'd1, "kb1_pre");
        exp_at(base + 62, 1'b0, 16'h0003, 1'b1, 2'd0, "kb1_hit");
        exp_at(base + 76, 1'b0, 16'hFFFF, 1'b1, 2'd0, "kb1_top");
        exp_at(base + 77, 1'b0, 16'h7FFF, 1'b1, 2'd0, "kb1_turn");
        for (int n = 0; n <= 77; n++) begin
            flick_a = (n == 0 || n == 27 || n == 44 || n == 62);
            tick1();
        end
        flick_a = 1'b0;
        do_reset();

        // LOOP wraps to phase 0; clearing it ends the second pass.
        base = cyc + 1;
        exp_at(base + 51,  1'b0, 16'h0001, 1'b1, 2'd2, "lp_lo2");
        exp_at(base + 52,  1'b0, 16'h0003, 1'b1, 2'd0, "lp_wrap");
        exp_at(base + 66,  1'b0, 16'hFFFF, 1'b1, 2'd0, "lp_top");
        exp_at(base + 91,  1'b0, 16'h0001, 1'b1, 2'd1, "lp_lo1");
        exp_at(base + 92,  1'b0, 16'h0003, 1'b1, 2'd2, "lp_ph2");
        exp_at(base + 101, 1'b0, 16'h0001, 1'b1, 2'd2, "lp_last");
        exp_at(base + 102, 1'b0, 16'h0000, 1'b0, 2'd0, "lp_idle");
        for (int n = 0; n <= 103; n++) begin
            loop_a  = (n < 60);
            flick_a = (n == 0);
            tick1();
        end
        loop_a  = 1'b0;
        flick_a = 1'b0;

        // Instance B: STEP_DIV=4, FLICK held high well past the sweep.
        base = cyc + 1;
        exp_at(base + 0,  1'b1, 16'h0000, 1'b1, 2'd0, "b_start");
        exp_at(base + 3,  1'b1, 16'h0000, 1'b1, 2'd0, "b_wait");
        exp_at(base + 4,  1'b1, 16'h0001, 1'b1, 2'd0, "b_step1");
        exp_at(base + 7,  1'b1, 16'h0001, 1'b1, 2'd0, "b_hold1");
        exp_at(base + 8,  1'b1, 16'h0003, 1'b1, 2'd0, "b_step2");
        exp_at(base + 32, 1'b1, 16'h00FF, 1'b1, 2'd0, "b_top");
        exp_at(base + 35, 1'b1, 16'h00FF, 1'b1, 2'd0, "b_tophold");
        exp_at(base + 36, 1'b1, 16'h007F, 1'b1, 2'd0, "b_turn");
        exp_at(base + 56, 1'b1, 16'h0003, 1'b1, 2'd0, "b_lo");
        exp_at(base + 59, 1'b1, 16'h0003, 1'b1, 2'd0, "b_lohold");
        exp_at(base + 60, 1'b1, 16'h0000, 1'b0, 2'd0, "b_idle");
        exp_at(base + 64, 1'b1, 16'h0000, 1'b0, 2'd0, "b_no_restart");
        for (int n = 0; n <= 66; n++) begin
            flick_b = (n < 65);
            tick1();
        end
        flick_b = 1'b0;

        for (int i = 0; i < 50 && sb.size() > 0; i++) tick1();
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
